pll_lock_supervisor: RTL and testbench

Supervises the Gowin rPLL from the reference-clock side. It drives the PLL's reset input and consumes its lock output. It issues a clean, glitch-free system reset only after lock has been continuously stable for a programmable time. On lock timeout it retries the PLL reset, and on lock loss it re-asserts the system reset. It sits between the board oscillator/PLL wrapper and the design's reset tree, clocked by the PLL input clock because the PLL output is untrustworthy until locked.

---
 rtl/pll_lock_supervisor.sv | 99 +++++++++
 tb/tb_pll_lock_supervisor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the rPLL reset from the reference clock and
// releases a glitch-free system reset once lock has been stable long enough.
module pll_lock_supervisor #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             lock_s;
  logic             timeout;

  // Raw pll_lock is asynchronous to clkin; only lock_s is used downstream.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    if (relock_req) begin
      state_next = PLL_RST;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) state_next = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
          end else if (cnt == TO_LAST) begin
            state_next = PLL_RST;
            timeout    = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) state_next = WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_next = RUN;
        end
        RUN: begin
          if (!lock_s) state_next = WAIT_LOCK;
        end
        default: state_next = PLL_RST;
      endcase
    end
  end

  // Outputs decode next-state so they switch on the same edge as the state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      state <= state_next;
      if (state_next != state || relock_req) cnt <= '0;
      else if (state != RUN) cnt <= cnt + 1'b1;
      pll_reset <= (state_next == PLL_RST);
      sys_reset <= (state_next != RUN);
      locked    <= (state_next == RUN);
      lock_lost <= (state == RUN) && !lock_s && !relock_req;
      if (timeout && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short parameters (4/8/32).
module tb_pll_lock_supervisor;

  logic       clkin;
  logic       reset;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic       lock_lost;
  logic [7:0] retry_count;

  int testsRun;
  int testsFailed;

  pll_lock_supervisor #(
    .PLL_RESET_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .pll_lock(pll_lock),
    .relock_req(relock_req),
    .pll_reset(pll_reset),
    .sys_reset(sys_reset),
    .locked(locked),
    .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic relock);
    pll_lock   = lock;
    relock_req = relock;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Reset values, then the nominal release on edge 13 with lock already high.
  task automatic runNominal(input string tag);
    checkOutput({tag, "_rst_pll_reset"}, 32'(pll_reset), 32'd1);
    checkOutput({tag, "_rst_sys_reset"}, 32'(sys_reset), 32'd1);
    checkOutput({tag, "_rst_locked"}, 32'(locked), 32'd0);
    checkOutput({tag, "_rst_lock_lost"}, 32'(lock_lost), 32'd0);
    checkOutput({tag, "_rst_retry"}, 32'(retry_count), 32'd0);
    for (int e = 1; e <= 13; e++) begin
      tick(1);
      checkOutput($sformatf("%s_pll_reset_e%0d", tag, e), 32'(pll_reset), 32'(e < 4));
      checkOutput($sformatf("%s_sys_reset_e%0d", tag, e), 32'(sys_reset), 32'(e < 13));
      checkOutput($sformatf("%s_locked_e%0d", tag, e), 32'(locked), 32'(e >= 13));
    end
    checkOutput({tag, "_retry_end"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    applyStimulus(1'b1, 1'b0);

    // Nominal power-up with lock tied high.
    applyReset();
    runNominal("nominal");

    // Lock loss in RUN: pulse appears on the third edge after the drop.
    applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      checkOutput($sformatf("loss_sys_reset_e%0d", e), 32'(sys_reset), 32'(e >= 3));
      checkOutput($sformatf("loss_locked_e%0d", e), 32'(locked), 32'(e < 3));
      checkOutput($sformatf("loss_lock_lost_e%0d", e), 32'(lock_lost), 32'(e == 3));
    end
    applyStimulus(1'b1, 1'b0);
    // lock_s rises on edge 6 of this count; release is 9 edges later, on edge 15.
    for (int e = 5; e <= 15; e++) begin
      tick(1);
      checkOutput($sformatf("relock_sys_reset_e%0d", e), 32'(sys_reset), 32'(e < 15));
      checkOutput($sformatf("relock_lock_lost_e%0d", e), 32'(lock_lost), 32'd0);
    end
    checkOutput("loss_retry", 32'(retry_count), 32'd0);

    // Glitch in STABLE at cnt=5: restarts stability, no retry.
    applyReset();
    tick(10);
    checkOutput("glitch_pre_sys_reset", 32'(sys_reset), 32'd1);
    applyStimulus(1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b1, 1'b0);
    for (int e = 13; e <= 23; e++) begin
      tick(1);
      checkOutput($sformatf("glitch_sys_reset_e%0d", e), 32'(sys_reset), 32'(e < 23));
      checkOutput($sformatf("glitch_locked_e%0d", e), 32'(locked), 32'(e >= 23));
      checkOutput($sformatf("glitch_pll_reset_e%0d", e), 32'(pll_reset), 32'd0);
    end
    checkOutput("glitch_retry", 32'(retry_count), 32'd0);

    // relock_req together with lock drop in RUN: PLL_RST, no lock_lost.
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("relock_sys_reset_e1", 32'(sys_reset), 32'd1);
    checkOutput("relock_pll_reset_e1", 32'(pll_reset), 32'd1);
    checkOutput("relock_lock_lost_e1", 32'(lock_lost), 32'd0);
    for (int e = 2; e <= 6; e++) begin
      tick(1);
      checkOutput($sformatf("relock_pll_reset_e%0d", e), 32'(pll_reset), 32'(e <= 4));
      checkOutput($sformatf("relock_lock_lost_e%0d", e), 32'(lock_lost), 32'd0);
      checkOutput($sformatf("relock_sys_reset_e%0d", e), 32'(sys_reset), 32'd1);
    end

    // Lock tied low: retry every 36 edges, saturating at 255.
    applyReset();
    tick(35);
    checkOutput("timeout_pll_reset_e35", 32'(pll_reset), 32'd0);
    checkOutput("timeout_retry_e35", 32'(retry_count), 32'd0);
    for (int k = 1; k <= 256; k++) begin
      tick(1);
      checkOutput($sformatf("timeout_pll_reset_k%0d", k), 32'(pll_reset), 32'd1);
      checkOutput($sformatf("timeout_retry_k%0d", k), 32'(retry_count), (k < 255) ? 32'(k) : 32'd255);
      checkOutput($sformatf("timeout_sys_reset_k%0d", k), 32'(sys_reset), 32'd1);
      if (k < 256) tick(35);
    end

    // Async reset mid-STABLE clears everything without a clock edge.
    applyStimulus(1'b1, 1'b0);
    tick(8);
    checkOutput("async_pre_pll_reset", 32'(pll_reset), 32'd0);
    checkOutput("async_pre_retry", 32'(retry_count), 32'd255);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_pll_reset", 32'(pll_reset), 32'd1);
    checkOutput("async_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_retry", 32'(retry_count), 32'd0);
    #1;
    reset = 1'b0;
    runNominal("after_async");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
